// File: rtl/crc32_mpeg2_checker.sv
// Receive-side CRC-32/MPEG-2 frame checker. Runs a bit-serial LFSR over every
// byte of a frame, including the trailing 4-byte CRC, and reports a
// pass/fail verdict when the frame ends. A zero residue means the frame passed.
module crc32_mpeg2_checker #(
    parameter logic [31:0] INIT  = 32'hFFFF_FFFF,
    parameter logic [31:0] POLY  = 32'h04C1_1DB7,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic             frame_done,
    output logic             crc_ok,
    output logic             len_err,
    output logic [CNT_W-1:0] byte_count,
    output logic [31:0]      crc_residue
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(4);

    state_t           state_q, state_d;
    logic [31:0]      lfsr_q, lfsr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       byte_q, byte_d;
    logic             last_q, last_d;
    logic [2:0]       idx_q, idx_d;
    logic             crc_ok_q, crc_ok_d;
    logic             len_err_q, len_err_d;
    logic [CNT_W-1:0] byte_count_q, byte_count_d;
    logic [31:0]      residue_q, residue_d;

    logic             fb;
    logic [31:0]      lfsr_step;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            lfsr_q       <= INIT;
            count_q      <= '0;
            byte_q       <= '0;
            last_q       <= 1'b0;
            idx_q        <= '0;
            crc_ok_q     <= 1'b0;
            len_err_q    <= 1'b0;
            byte_count_q <= '0;
            residue_q    <= '0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            count_q      <= count_d;
            byte_q       <= byte_d;
            last_q       <= last_d;
            idx_q        <= idx_d;
            crc_ok_q     <= crc_ok_d;
            len_err_q    <= len_err_d;
            byte_count_q <= byte_count_d;
            residue_q    <= residue_d;
        end
    end

    // Next-state logic: accept a byte, shift it MSB first, then publish the verdict
    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        count_d      = count_q;
        byte_d       = byte_q;
        last_d       = last_q;
        idx_d        = idx_q;
        crc_ok_d     = crc_ok_q;
        len_err_d    = len_err_q;
        byte_count_d = byte_count_q;
        residue_d    = residue_q;

        fb        = lfsr_q[31] ^ byte_q[idx_q];
        lfsr_step = {lfsr_q[30:0], 1'b0} ^ (fb ? POLY : '0);

        unique case (state_q)
            IDLE: begin
                if (s_valid && s_ready) begin
                    byte_d  = s_data;
                    last_d  = s_last;
                    count_d = (count_q == '1) ? count_q : count_q + 1'b1;
                    idx_d   = 3'd7;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                lfsr_d = lfsr_step;
                idx_d  = idx_q - 3'd1;
                if (idx_q == 3'd0) begin
                    if (last_q) begin
                        // Result registers load on entry to DONE so they are already
                        // valid while frame_done is high.
                        residue_d    = lfsr_step;
                        byte_count_d = count_q;
                        len_err_d    = (count_q < MIN_LEN);
                        crc_ok_d     = (lfsr_step == '0) && (count_q >= MIN_LEN);
                        state_d      = DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DONE: begin
                lfsr_d  = INIT;
                count_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign s_ready     = (state_q == IDLE) && !rst;
    assign frame_done  = (state_q == DONE) && !rst;
    assign crc_ok      = crc_ok_q;
    assign len_err     = len_err_q;
    assign byte_count  = byte_count_q;
    assign crc_residue = residue_q;

endmodule

// File: tb/tb_crc32_mpeg2_checker.sv
// Self-checking bench for crc32_mpeg2_checker: directed frames plus random
// frames, compared against a whole-message CRC reference model.
module tb_crc32_mpeg2_checker;

    localparam int unsigned CNT_W = 4;
    localparam logic [31:0] INIT  = 32'hFFFF_FFFF;
    localparam logic [31:0] POLY  = 32'h04C1_1DB7;

    typedef logic [7:0] bq_t[$];

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       s_data;
    logic             s_valid;
    logic             s_last;
    logic             s_ready;
    logic             frame_done;
    logic             crc_ok;
    logic             len_err;
    logic [CNT_W-1:0] byte_count;
    logic [31:0]      crc_residue;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;

    crc32_mpeg2_checker #(
        .INIT (INIT),
        .POLY (POLY),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .frame_done (frame_done),
        .crc_ok     (crc_ok),
        .len_err    (len_err),
        .byte_count (byte_count),
        .crc_residue(crc_residue)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done) pulses++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: polynomial division of the whole message, MSB of each byte first
    function automatic logic [31:0] ref_crc(input bq_t q);
        logic [31:0] c;
        logic        top;
        c = INIT;
        foreach (q[k]) begin
            for (int b = 7; b >= 0; b--) begin
                top = c[31] ^ q[k][b];
                c   = c << 1;
                if (top) c = c ^ POLY;
            end
        end
        return c;
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic last, input int unsigned gap);
        int t;
        for (int g = 0; g < int'(gap); g++) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            s_last  = 1'($urandom);
        end
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        t = 0;
        while (!s_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        check_eq("ready_wait", 32'(t >= 40), 32'd0);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        s_last  = 1'($urandom);
    endtask

    task automatic send_frame(input bq_t q, input logic gaps, input logic [31:0] exp_res);
        int          n;
        int          lat;
        logic [31:0] cnt_exp;
        n       = q.size();
        cnt_exp = (n > 15) ? 32'd15 : 32'(n);
        for (int k = 0; k < n; k++)
            send_byte(q[k], (k == n - 1), gaps ? $urandom_range(0, 3) : 0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!frame_done && lat < 20);
        check_eq("done_latency", 32'(lat), 32'd9);
        check_eq("crc_residue", crc_residue, exp_res);
        check_eq("crc_ok", 32'(crc_ok), 32'((exp_res == 0) && (n >= 4)));
        check_eq("len_err", 32'(len_err), 32'(n < 4));
        check_eq("byte_count", 32'(byte_count), cnt_exp);
        @(negedge clk);
        check_eq("pulse_width", 32'(frame_done), 32'd0);
        check_eq("ready_after", 32'(s_ready), 32'd1);
        check_eq("residue_hold", crc_residue, exp_res);
    endtask

    initial begin
        bq_t         good, bad, q, pay;
        logic [31:0] c;
        int          acc;
        int          p0;
        logic        exp_rdy;

        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", 32'(s_ready), 32'd0);
        check_eq("rst_done", 32'(frame_done), 32'd0);
        check_eq("rst_ok", 32'(crc_ok), 32'd0);
        check_eq("rst_len", 32'(len_err), 32'd0);
        check_eq("rst_cnt", 32'(byte_count), 32'd0);
        check_eq("rst_res", crc_residue, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("ready_idle", 32'(s_ready), 32'd1);

        // Known-good frame: "123456789" followed by its CRC
        good = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                 8'h03, 8'h76, 8'hE6, 8'hE7};
        send_frame(good, 1'b0, 32'd0);

        // Corrupted payload byte
        bad    = good;
        bad[4] = 8'h34;
        c      = ref_crc(bad);
        check_eq("bad_nonzero", 32'(crc_residue != 0 || c == 0), 32'd0);
        send_frame(bad, 1'b1, c);
        check_eq("bad_nonzero_dut", 32'(crc_residue != 0), 32'd1);

        // Back-to-back good frames
        send_frame(good, 1'b0, 32'd0);
        send_frame(good, 1'b0, 32'd0);

        // Single zero byte
        q = '{8'h00};
        send_frame(q, 1'b0, 32'h4E08_BFB4);

        // Handshake with s_valid held high across a 3-byte frame
        acc = 0;
        for (int i = 0; i < 29; i++) begin
            @(negedge clk);
            s_valid = (acc < 3);
            s_data  = 8'(8'h10 + acc);
            s_last  = (acc == 2);
            exp_rdy = (i == 0 || i == 9 || i == 18 || i == 28);
            check_eq("hs_ready", 32'(s_ready), 32'(exp_rdy));
            if (i == 27) check_eq("hs_done", 32'(frame_done), 32'd1);
            if (s_valid && s_ready) acc++;
        end
        s_valid = 1'b0;
        check_eq("hs_accepts", 32'(acc), 32'd3);
        q = '{8'h10, 8'h11, 8'h12};
        check_eq("hs_residue", crc_residue, ref_crc(q));
        check_eq("hs_len_err", 32'(len_err), 32'd1);
        check_eq("hs_count", 32'(byte_count), 32'd3);

        // Reset in the middle of a frame
        p0 = pulses;
        for (int k = 0; k < 5; k++) send_byte(good[k], 1'b0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("midrst_ready", 32'(s_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_ok", 32'(crc_ok), 32'd0);
        check_eq("midrst_len", 32'(len_err), 32'd0);
        check_eq("midrst_cnt", 32'(byte_count), 32'd0);
        check_eq("midrst_res", crc_residue, 32'd0);
        repeat (12) @(negedge clk);
        check_eq("midrst_nopulse", 32'(pulses), 32'(p0));
        send_frame(good, 1'b0, 32'd0);

        // Random frames, some with a valid appended CRC, some saturating the counter
        for (int r = 0; r < 14; r++) begin
            q = {};
            if ($urandom_range(0, 1) == 1) begin
                pay = {};
                for (int k = 0; k < int'($urandom_range(0, 18)); k++) pay.push_back(8'($urandom));
                c = ref_crc(pay);
                q = pay;
                q.push_back(c[31:24]);
                q.push_back(c[23:16]);
                q.push_back(c[15:8]);
                q.push_back(c[7:0]);
            end else begin
                for (int k = 0; k < int'($urandom_range(1, 22)); k++) q.push_back(8'($urandom));
            end
            send_frame(q, 1'($urandom), ref_crc(q));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
